// File: rtl/cache_ctrl_burst_if.sv
// Core request, datapath status/control and burst pmem signals of cache_ctrl_burst.
// slave = the controller, master = the environment (core, datapath, pmem).
interface cache_ctrl_burst_if #(
    parameter int WAYS  = 2,
    parameter int BEATS = 4,
    parameter int CNT_W = 32
);
    localparam int WAY_W  = $clog2(WAYS);
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    // core side
    logic              mem_read;
    logic              mem_write;
    logic              mem_resp;
    // datapath status
    logic              hit;
    logic              valid;
    logic              dirty;
    logic [WAYS-1:0]   hit_way;
    logic [WAY_W-1:0]  lru_way;
    // physical memory burst port
    logic              pmem_read;
    logic              pmem_write;
    logic              pmem_resp;
    logic [BEAT_W-1:0] beat_idx;
    // datapath control
    logic [WAYS-1:0]   way_sel;
    logic              load_line_data;
    logic              load_valid;
    logic              load_dirty;
    logic              load_lru;
    logic              line_datain_sel;
    logic              dirty_in;
    logic              address_sel;
    logic              miss;
    // performance counters
    logic [CNT_W-1:0]  hit_count;
    logic [CNT_W-1:0]  miss_count;

    modport slave (
        input  mem_read, mem_write, hit, valid, dirty, hit_way, lru_way, pmem_resp,
        output mem_resp, pmem_read, pmem_write, beat_idx, way_sel,
               load_line_data, load_valid, load_dirty, load_lru,
               line_datain_sel, dirty_in, address_sel, miss,
               hit_count, miss_count
    );

    modport master (
        output mem_read, mem_write, hit, valid, dirty, hit_way, lru_way, pmem_resp,
        input  mem_resp, pmem_read, pmem_write, beat_idx, way_sel,
               load_line_data, load_valid, load_dirty, load_lru,
               line_datain_sel, dirty_in, address_sel, miss,
               hit_count, miss_count
    );
endinterface

// File: rtl/cache_ctrl_burst.sv
// N-way L1 cache control FSM (hit, multi-beat write-back, multi-beat fill); counters under CACHE_CTRL_PERF_EN.
// Hit resolves same cycle; miss takes 1 + BEATS (+BEATS if dirty) pmem_resp beats, stalling while pmem_resp is low.
module cache_ctrl_burst #(
    parameter int WAYS  = 2,
    parameter int BEATS = 4,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    cache_ctrl_burst_if.slave bus
);
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        READY      = 2'd0,
        WRITE_BACK = 2'd1,
        FILL       = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WAYS-1:0]   victim;
    logic [BEAT_W-1:0] beat_cnt;

    logic req;
    logic hit_ok;
    logic last_beat;
    logic miss_start;

    logic              mem_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [WAYS-1:0]   way_sel;
    logic              load_line_data;
    logic              load_valid;
    logic              load_dirty;
    logic              load_lru;
    logic              line_datain_sel;
    logic              dirty_in;
    logic              address_sel;
    logic              miss;

    assign req        = bus.mem_read | bus.mem_write;
    assign hit_ok     = bus.hit & bus.valid;
    assign last_beat  = (beat_cnt == LAST_BEAT);
    assign miss_start = (state == READY) && req && !hit_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= READY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            READY: begin
                if (miss_start) begin
                    state_nxt = (bus.valid && bus.dirty) ? WRITE_BACK : FILL;
                end
            end
            WRITE_BACK: begin
                if (bus.pmem_resp && last_beat) begin
                    state_nxt = FILL;
                end
            end
            FILL: begin
                if (bus.pmem_resp && last_beat) begin
                    state_nxt = READY;
                end
            end
            default: state_nxt = READY;
        endcase
    end

    // Victim is captured once at miss entry so LRU updates mid-miss cannot redirect the burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            victim   <= '0;
            beat_cnt <= '0;
        end else if (miss_start) begin
            victim   <= WAYS'(1) << bus.lru_way;
            beat_cnt <= '0;
        end else if ((state != READY) && bus.pmem_resp) begin
            beat_cnt <= last_beat ? '0 : beat_cnt + BEAT_W'(1);
        end
    end

    // Outputs are forced low while reset is asserted, even if the core keeps its request up.
    always_comb begin
        mem_resp        = 1'b0;
        pmem_read       = 1'b0;
        pmem_write      = 1'b0;
        way_sel         = '0;
        load_line_data  = 1'b0;
        load_valid      = 1'b0;
        load_dirty      = 1'b0;
        load_lru        = 1'b0;
        line_datain_sel = 1'b0;
        dirty_in        = 1'b0;
        address_sel     = 1'b0;
        miss            = 1'b0;
        if (rst_n) begin
            case (state)
                READY: begin
                    if (req) begin
                        if (hit_ok) begin
                            mem_resp = 1'b1;
                            load_lru = 1'b1;
                            way_sel  = bus.hit_way;
                            if (bus.mem_write) begin
                                load_line_data  = 1'b1;
                                load_dirty      = 1'b1;
                                dirty_in        = 1'b1;
                                line_datain_sel = 1'b1;
                            end
                        end else begin
                            miss = 1'b1;
                        end
                    end
                end
                WRITE_BACK: begin
                    pmem_write  = 1'b1;
                    address_sel = 1'b1;
                    way_sel     = victim;
                    miss        = 1'b1;
                end
                FILL: begin
                    pmem_read      = 1'b1;
                    way_sel        = victim;
                    miss           = 1'b1;
                    load_line_data = bus.pmem_resp;
                    if (bus.pmem_resp && last_beat) begin
                        load_valid = 1'b1;
                        load_dirty = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_resp        = mem_resp;
    assign bus.pmem_read       = pmem_read;
    assign bus.pmem_write      = pmem_write;
    assign bus.beat_idx        = rst_n ? beat_cnt : '0;
    assign bus.way_sel         = way_sel;
    assign bus.load_line_data  = load_line_data;
    assign bus.load_valid      = load_valid;
    assign bus.load_dirty      = load_dirty;
    assign bus.load_lru        = load_lru;
    assign bus.line_datain_sel = line_datain_sel;
    assign bus.dirty_in        = dirty_in;
    assign bus.address_sel     = address_sel;
    assign bus.miss            = miss;

`ifdef CACHE_CTRL_PERF_EN
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] miss_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (mem_resp && (hit_cnt != '1)) begin
                hit_cnt <= hit_cnt + CNT_W'(1);
            end
            if (miss_start && (miss_cnt != '1)) begin
                miss_cnt <= miss_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.hit_count  = hit_cnt;
    assign bus.miss_count = miss_cnt;
`else
    assign bus.hit_count  = {CNT_W{1'b0}};
    assign bus.miss_count = {CNT_W{1'b0}};
`endif

    a_pmem_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.pmem_read && bus.pmem_write));

    a_victim_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        (state != READY) |-> $onehot(victim));

endmodule

// File: tb/tb_cache_ctrl_burst.sv
// Scoreboard bench for cache_ctrl_burst: WAYS=4, BEATS=4, 3-bit counters so saturation is reachable.
module tb_cache_ctrl_burst;
    localparam int WAYS  = 4;
    localparam int BEATS = 4;
    localparam int CNT_W = 3;
`ifdef CACHE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cache_ctrl_burst_if #(.WAYS(WAYS), .BEATS(BEATS), .CNT_W(CNT_W)) bus();

    cache_ctrl_burst #(.WAYS(WAYS), .BEATS(BEATS), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic       pr;
        logic       pw;
        logic [1:0] beat;
        logic [3:0] way;
        logic       lld;
        logic       lv;
        logic       ld;
        logic       din;
        logic       asel;
        logic       lsel;
        logic       miss;
        logic       resp;
        logic       lru;
    } obs_t;

    obs_t exp_q[$];
    obs_t obs_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   both_high = 0;
    int   stall_bad = 0;

    always @(negedge clk) begin
        if (rst_n && bus.pmem_read && bus.pmem_write) both_high++;
    end

    function automatic obs_t sample();
        obs_t o;
        o.pr   = bus.pmem_read;
        o.pw   = bus.pmem_write;
        o.beat = bus.beat_idx;
        o.way  = bus.way_sel;
        o.lld  = bus.load_line_data;
        o.lv   = bus.load_valid;
        o.ld   = bus.load_dirty;
        o.din  = bus.dirty_in;
        o.asel = bus.address_sel;
        o.lsel = bus.line_datain_sel;
        o.miss = bus.miss;
        o.resp = bus.mem_resp;
        o.lru  = bus.load_lru;
        return o;
    endfunction

    function automatic obs_t exp_beat(input bit wr, input int b, input logic [3:0] way);
        obs_t e = '0;
        e.pr   = !wr;
        e.pw   = wr;
        e.beat = 2'(b);
        e.way  = way;
        e.lld  = !wr;
        e.lv   = !wr && (b == BEATS - 1);
        e.ld   = !wr && (b == BEATS - 1);
        e.asel = wr;
        e.miss = 1'b1;
        return e;
    endfunction

    function automatic obs_t exp_hit(input logic [3:0] way, input bit wr);
        obs_t e = '0;
        e.resp = 1'b1;
        e.lru  = 1'b1;
        e.way  = way;
        e.lld  = wr;
        e.ld   = wr;
        e.din  = wr;
        e.lsel = wr;
        return e;
    endfunction

    function automatic obs_t exp_miss_entry();
        obs_t e = '0;
        e.miss = 1'b1;
        return e;
    endfunction

    task automatic push_miss(input bit dirty_victim, input logic [3:0] way);
        if (dirty_victim) for (int b = 0; b < BEATS; b++) exp_q.push_back(exp_beat(1'b1, b, way));
        for (int b = 0; b < BEATS; b++) exp_q.push_back(exp_beat(1'b0, b, way));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.hit       = 1'b0;
        bus.valid     = 1'b0;
        bus.dirty     = 1'b0;
        bus.hit_way   = '0;
        bus.lru_way   = '0;
        bus.pmem_resp = 1'b0;
    endtask

    // Serves nbeats pmem beats with gap idle cycles before each; records each beat's outputs.
    task automatic run_pmem(input int nbeats, input int gap);
        for (int b = 0; b < nbeats; b++) begin
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                if (bus.load_line_data || bus.load_valid || bus.beat_idx != 2'(b % BEATS)) stall_bad++;
                tick();
            end
            bus.pmem_resp = 1'b1;
            @(negedge clk);
            obs_q.push_back(sample());
            tick();
            bus.pmem_resp = 1'b0;
        end
    endtask

    // Starts a miss in the drive phase and checks the READY miss-detect cycle.
    task automatic start_miss(input string name, input bit wr, input bit dirty_victim, input logic [1:0] lru);
        obs_t o;
        bus.mem_read  = !wr;
        bus.mem_write = wr;
        bus.hit       = 1'b0;
        bus.valid     = dirty_victim;
        bus.dirty     = dirty_victim;
        bus.lru_way   = lru;
        push_miss(dirty_victim, 4'(1 << lru));
        @(negedge clk);
        o = sample();
        vectors++;
        if (o !== exp_miss_entry()) begin
            miscompares++;
            $display("FAIL %s_entry: got %h expected %h", name, o, exp_miss_entry());
        end
        tick();
    endtask

    task automatic test_reset();
        obs_t o;
        idle_inputs();
        rst_n = 1'b0;
        #2;
        o = sample();
        vectors++;
        if (o !== '0 || bus.hit_count !== '0 || bus.miss_count !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h/%0d/%0d expected 0/0/0", o, bus.hit_count, bus.miss_count);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        o = sample();
        vectors++;
        if (o !== '0) begin
            miscompares++;
            $display("FAIL reset_idle: got %h expected 0", o);
        end
        tick();
    endtask

    task automatic test_read_hit();
        obs_t o;
        bus.mem_read = 1'b1;
        bus.hit      = 1'b1;
        bus.valid    = 1'b1;
        bus.hit_way  = 4'b0100;
        @(negedge clk);
        o = sample();
        vectors++;
        if (o !== exp_hit(4'b0100, 1'b0)) begin
            miscompares++;
            $display("FAIL read_hit: got %h expected %h", o, exp_hit(4'b0100, 1'b0));
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_write_hit();
        obs_t o;
        bus.mem_write = 1'b1;
        bus.hit       = 1'b1;
        bus.valid     = 1'b1;
        bus.hit_way   = 4'b0010;
        @(negedge clk);
        o = sample();
        vectors++;
        if (o !== exp_hit(4'b0010, 1'b1)) begin
            miscompares++;
            $display("FAIL write_hit: got %h expected %h", o, exp_hit(4'b0010, 1'b1));
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_read_write_both();
        obs_t o;
        bus.mem_read  = 1'b1;
        bus.mem_write = 1'b1;
        bus.hit       = 1'b1;
        bus.valid     = 1'b1;
        bus.hit_way   = 4'b0001;
        @(negedge clk);
        o = sample();
        vectors++;
        if (o !== exp_hit(4'b0001, 1'b1)) begin
            miscompares++;
            $display("FAIL read_write_both: got %h expected %h", o, exp_hit(4'b0001, 1'b1));
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_clean_read_miss();
        obs_t o, e;
        start_miss("clean_miss", 1'b0, 1'b0, 2'd3);
        run_pmem(BEATS, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (obs_q.size() == 0) begin
                miscompares++;
                $display("FAIL clean_miss_beat: got none expected %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    miscompares++;
                    $display("FAIL clean_miss_beat: got %h expected %h", o, e);
                end
            end
        end
        bus.hit     = 1'b1;
        bus.valid   = 1'b1;
        bus.hit_way = 4'b1000;
        @(negedge clk);
        o = sample();
        vectors++;
        if (o !== exp_hit(4'b1000, 1'b0)) begin
            miscompares++;
            $display("FAIL clean_miss_final_hit: got %h expected %h", o, exp_hit(4'b1000, 1'b0));
        end
        tick();
        idle_inputs();
        obs_q.delete();
    endtask

    task automatic test_dirty_write_miss();
        obs_t o, e;
        start_miss("dirty_miss", 1'b1, 1'b1, 2'd3);
        bus.lru_way = 2'd0;
        bus.valid   = 1'b0;
        bus.dirty   = 1'b0;
        run_pmem(2 * BEATS, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (obs_q.size() == 0) begin
                miscompares++;
                $display("FAIL dirty_miss_beat: got none expected %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    miscompares++;
                    $display("FAIL dirty_miss_beat: got %h expected %h", o, e);
                end
            end
        end
        bus.hit     = 1'b1;
        bus.valid   = 1'b1;
        bus.hit_way = 4'b1000;
        @(negedge clk);
        o = sample();
        vectors++;
        if (o !== exp_hit(4'b1000, 1'b1)) begin
            miscompares++;
            $display("FAIL dirty_miss_write_hit: got %h expected %h", o, exp_hit(4'b1000, 1'b1));
        end
        tick();
        idle_inputs();
        obs_q.delete();
    endtask

    task automatic test_stall();
        obs_t o, e;
        stall_bad = 0;
        start_miss("stall", 1'b0, 1'b0, 2'd1);
        run_pmem(BEATS, 3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (obs_q.size() == 0) begin
                miscompares++;
                $display("FAIL stall_beat: got none expected %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    miscompares++;
                    $display("FAIL stall_beat: got %h expected %h", o, e);
                end
            end
        end
        vectors++;
        if (stall_bad !== 0) begin
            miscompares++;
            $display("FAIL stall_hold: got %0d bad stall cycles expected 0", stall_bad);
        end
        idle_inputs();
        tick();
        obs_q.delete();
    endtask

    task automatic test_dropped_request();
        obs_t o, e;
        start_miss("dropped", 1'b0, 1'b0, 2'd2);
        bus.mem_read = 1'b0;
        run_pmem(BEATS, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (obs_q.size() == 0) begin
                miscompares++;
                $display("FAIL dropped_beat: got none expected %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    miscompares++;
                    $display("FAIL dropped_beat: got %h expected %h", o, e);
                end
            end
        end
        bus.hit     = 1'b1;
        bus.valid   = 1'b1;
        bus.hit_way = 4'b0100;
        @(negedge clk);
        o = sample();
        vectors++;
        if (o !== '0) begin
            miscompares++;
            $display("FAIL dropped_no_resp: got %h expected 0", o);
        end
        tick();
        idle_inputs();
        obs_q.delete();
    endtask

    task automatic test_reset_mid_fill();
        obs_t o;
        start_miss("rst_fill", 1'b0, 1'b0, 2'd0);
        exp_q.delete();
        run_pmem(2, 0);
        @(negedge clk);
        vectors++;
        if (bus.beat_idx !== 2'd2 || bus.pmem_read !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_fill_pre: got beat %0d pmem_read %b expected 2 1", bus.beat_idx, bus.pmem_read);
        end
        #2;
        rst_n = 1'b0;
        #1;
        o = sample();
        vectors++;
        if (o !== '0 || bus.hit_count !== '0 || bus.miss_count !== '0) begin
            miscompares++;
            $display("FAIL rst_fill_assert: got %h/%0d/%0d expected 0/0/0", o, bus.hit_count, bus.miss_count);
        end
        idle_inputs();
        tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        o = sample();
        vectors++;
        if (o !== '0) begin
            miscompares++;
            $display("FAIL rst_fill_idle: got %h expected 0", o);
        end
        tick();
        obs_q.delete();
    endtask

    task automatic test_perf_counters();
        int exp_h = 0;
        int exp_m = 0;
        for (int i = 0; i < 5; i++) begin
            bus.mem_read = 1'b1;
            bus.hit      = 1'b1;
            bus.valid    = 1'b1;
            bus.hit_way  = 4'(1 << (i % WAYS));
            tick();
            idle_inputs();
            exp_h++;
        end
        for (int i = 0; i < 2; i++) begin
            start_miss("perf_miss", 1'b0, 1'b0, 2'(i));
            exp_m++;
            run_pmem(BEATS, 0);
            bus.hit     = 1'b1;
            bus.valid   = 1'b1;
            bus.hit_way = 4'(1 << i);
            tick();
            idle_inputs();
            exp_h++;
        end
        @(negedge clk);
        vectors++;
        if (bus.hit_count !== CNT_W'(PERF ? exp_h : 0) || bus.miss_count !== CNT_W'(PERF ? exp_m : 0)) begin
            miscompares++;
            $display("FAIL perf_counts: got %0d/%0d expected %0d/%0d", bus.hit_count, bus.miss_count,
                     PERF ? exp_h : 0, PERF ? exp_m : 0);
        end
        tick();
        bus.mem_read = 1'b1;
        bus.hit      = 1'b1;
        bus.valid    = 1'b1;
        bus.hit_way  = 4'b0001;
        tick();
        idle_inputs();
        for (int i = 0; i < 6; i++) begin
            start_miss("perf_sat_miss", 1'b0, 1'b0, 2'(i % WAYS));
            bus.mem_read = 1'b0;
            run_pmem(BEATS, 0);
        end
        exp_q.delete();
        obs_q.delete();
        @(negedge clk);
        vectors++;
        if (bus.hit_count !== CNT_W'(PERF ? 7 : 0) || bus.miss_count !== CNT_W'(PERF ? 7 : 0)) begin
            miscompares++;
            $display("FAIL perf_saturate: got %0d/%0d expected %0d/%0d", bus.hit_count, bus.miss_count,
                     PERF ? 7 : 0, PERF ? 7 : 0);
        end
        tick();
    endtask

    task automatic test_no_overlap();
        vectors++;
        if (both_high !== 0) begin
            miscompares++;
            $display("FAIL pmem_overlap: got %0d cycles with both high expected 0", both_high);
        end
    endtask

    initial begin
        test_reset();
        test_read_hit();
        test_write_hit();
        test_read_write_both();
        test_clean_read_miss();
        test_dirty_write_miss();
        test_stall();
        test_dropped_request();
        test_reset_mid_fill();
        test_perf_counters();
        test_no_overlap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
